// File: rtl/blink_pkg.sv
// Shared encodings for the LED sequencer: switch-mode codes, FSM states and bounce direction.
package blink_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_CHASE  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    // State encoding equals the switch encoding so a synchronised SW value maps directly.
    typedef enum logic [1:0] {
        S_OFF    = MODE_OFF,
        S_BLINK  = MODE_BLINK,
        S_CHASE  = MODE_CHASE,
        S_BOUNCE = MODE_BOUNCE
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic state_e mode_to_state(input logic [1:0] mode);
        return state_e'(mode);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock into a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic KEY,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// Tick-driven LED pattern sequencer (off / blink / chase / bounce) selected by SW.
// Optional BLINK_SEQ_PWM_EN adds SW_DUTY and a 16-step PWM dimmer on LEDG.
module blink_sequencer #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned N_LED    = 8
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic [1:0]       SW,
`ifdef BLINK_SEQ_PWM_EN
    input  logic [3:0]       SW_DUTY,
`endif
    output logic [N_LED-1:0] LEDG,
    output logic             tick
);

    import blink_pkg::*;

    localparam logic [N_LED-1:0] PAT_FIRST = {{(N_LED-1){1'b0}}, 1'b1};

    logic [1:0]       sw_meta_q, sw_s_q;
    state_e           state_q, sw_state;
    logic [N_LED-1:0] pattern_q;
    logic             dir_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            sw_meta_q <= MODE_OFF;
            sw_s_q    <= MODE_OFF;
        end else begin
            sw_meta_q <= SW;
            sw_s_q    <= sw_meta_q;
        end
    end

    assign sw_state = mode_to_state(sw_s_q);

    // A mode change loads the new state's seed pattern; it does not also step.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q   <= S_OFF;
            pattern_q <= '0;
            dir_q     <= DIR_LEFT;
        end else if (tick) begin
            if (sw_state != state_q) begin
                state_q <= sw_state;
                dir_q   <= DIR_LEFT;
                unique case (sw_state)
                    S_OFF:    pattern_q <= '0;
                    S_BLINK:  pattern_q <= '1;
                    S_CHASE:  pattern_q <= PAT_FIRST;
                    S_BOUNCE: pattern_q <= PAT_FIRST;
                endcase
            end else begin
                unique case (state_q)
                    S_OFF:   pattern_q <= '0;
                    S_BLINK: pattern_q <= ~pattern_q;
                    S_CHASE: pattern_q <= {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                    S_BOUNCE: begin
                        // Turn around on the step that lands on an end LED.
                        if (dir_q == DIR_LEFT) begin
                            pattern_q <= pattern_q << 1;
                            if (pattern_q[N_LED-2]) dir_q <= DIR_RIGHT;
                        end else begin
                            pattern_q <= pattern_q >> 1;
                            if (pattern_q[1]) dir_q <= DIR_LEFT;
                        end
                    end
                endcase
            end
        end
    end

`ifdef BLINK_SEQ_PWM_EN
    logic [3:0] duty_meta_q, duty_s_q, pwm_cnt_q;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            duty_meta_q <= '0;
            duty_s_q    <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            duty_meta_q <= SW_DUTY;
            duty_s_q    <= duty_meta_q;
            pwm_cnt_q   <= pwm_cnt_q + 4'd1;
        end
    end

    assign LEDG = pattern_q & {N_LED{pwm_cnt_q <= duty_s_q}};
`else
    assign LEDG = pattern_q;
`endif

endmodule
